// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, status and control strobes between datapath and controller
//
// Signals:
//   op, funct3, funct7b5   instruction fields from the instruction register
//   zero_flag, mem_ready   datapath / memory status
//   PCWrite .. RegWrite    control strobes and mux selects to the datapath
//   state                  current controller state, debug only
//   illegal_instr          present only when MC_CTRL_TRAP_EN is defined
// Modports: master = datapath side, slave = controller side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero_flag;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic [3:0] state;
`ifdef MC_CTRL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        output op, funct3, funct7b5, zero_flag, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
        input  ImmSrc, ALUControl, RegWrite, state
`ifdef MC_CTRL_TRAP_EN
        , input illegal_instr
`endif
    );

    modport slave (
        input  op, funct3, funct7b5, zero_flag, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
        output ImmSrc, ALUControl, RegWrite, state
`ifdef MC_CTRL_TRAP_EN
        , output illegal_instr
`endif
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore-FSM controller for a multicycle RISC-V style datapath
//
// Ports:
//   clk    rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    multicycle_controller_if.slave: instruction fields, zero_flag,
//          mem_ready in; control strobes, selects, ALUControl, state out
// Optional feature: macro MC_CTRL_TRAP_EN adds a TRAP state and the
// illegal_instr output; without it an unknown opcode is a 2-cycle NOP.
module multicycle_controller (
    input  logic                         clk,
    input  logic                         Reset,
    multicycle_controller_if.slave       bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
`ifdef MC_CTRL_TRAP_EN
        , TRAP   = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q, state_d;
    logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // Strobes follow mem_ready so a stalled fetch loads PC/IR only once.
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
`ifdef MC_CTRL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.ALUControl = 3'b000;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // FETCH strobes depend on mem_ready combinationally, so they are also
    // masked by Reset to stay quiet while reset is held.
    assign bus.PCWrite   = Reset & (pc_update | (branch & bus.zero_flag));
    assign bus.IRWrite   = Reset & ir_write;
    assign bus.MemWrite  = mem_write;
    assign bus.RegWrite  = reg_write;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.state     = state_q;
`ifdef MC_CTRL_TRAP_EN
    assign bus.illegal_instr = (state_q == TRAP);
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic Reset;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        Reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op        = 7'b0000000;
        bus.funct3    = 3'b000;
        bus.funct7b5  = 1'b0;
        bus.zero_flag = 1'b0;

        // Reset held 3 cycles with mem_ready=1
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_state", 8'(bus.state), 8'd0);
            chk("rst_pcw",   8'(bus.PCWrite), 8'd0);
            chk("rst_irw",   8'(bus.IRWrite), 8'd0);
            chk("rst_memw",  8'(bus.MemWrite), 8'd0);
            chk("rst_regw",  8'(bus.RegWrite), 8'd0);
        end

        // Release with memory stalled: no fetch strobes yet
        Reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("stall_pcw", 8'(bus.PCWrite), 8'd0);
        chk("stall_irw", 8'(bus.IRWrite), 8'd0);
        tick();
        chk("stall_state", 8'(bus.state), 8'd0);

        // lw
        bus.mem_ready = 1'b1;
        bus.op = 7'b0000011;
        #1;
        chk("fetch_pcw", 8'(bus.PCWrite), 8'd1);
        chk("fetch_irw", 8'(bus.IRWrite), 8'd1);
        chk("fetch_srcb", 8'(bus.ALUSrcB), 8'd2);
        chk("fetch_res", 8'(bus.ResultSrc), 8'd2);
        chk("lw_imm", 8'(bus.ImmSrc), 8'd0);
        tick();
        chk("lw_s1", 8'(bus.state), 8'd1);
        chk("dec_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("dec_srcb", 8'(bus.ALUSrcB), 8'd1);
        chk("dec_pcw", 8'(bus.PCWrite), 8'd0);
        tick();
        chk("lw_s2", 8'(bus.state), 8'd2);
        chk("madr_srca", 8'(bus.ALUSrcA), 8'd2);
        chk("madr_alu", 8'(bus.ALUControl), 8'd0);
        tick();
        chk("lw_s3", 8'(bus.state), 8'd3);
        chk("mread_adr", 8'(bus.AdrSrc), 8'd1);
        chk("mread_regw", 8'(bus.RegWrite), 8'd0);
        tick();
        chk("lw_s4", 8'(bus.state), 8'd4);
        chk("mwb_regw", 8'(bus.RegWrite), 8'd1);
        chk("mwb_res", 8'(bus.ResultSrc), 8'd1);
        tick();
        chk("lw_s0", 8'(bus.state), 8'd0);
        chk("lw_end_regw", 8'(bus.RegWrite), 8'd0);

        // sw with 3 stall cycles in MEMWRITE
        bus.op = 7'b0100011;
        #1;
        chk("sw_imm", 8'(bus.ImmSrc), 8'd1);
        tick();
        chk("sw_s1", 8'(bus.state), 8'd1);
        tick();
        chk("sw_s2", 8'(bus.state), 8'd2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_stall_state", 8'(bus.state), 8'd5);
            chk("sw_stall_memw", 8'(bus.MemWrite), 8'd1);
            chk("sw_stall_adr", 8'(bus.AdrSrc), 8'd1);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("sw_last_memw", 8'(bus.MemWrite), 8'd1);
        tick();
        chk("sw_s0", 8'(bus.state), 8'd0);
        chk("sw_end_memw", 8'(bus.MemWrite), 8'd0);

        // R-type sub
        bus.op = 7'b0110011;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b1;
        tick();
        tick();
        chk("sub_s6", 8'(bus.state), 8'd6);
        chk("sub_alu", 8'(bus.ALUControl), 8'd1);
        chk("sub_srca", 8'(bus.ALUSrcA), 8'd2);
        chk("sub_srcb", 8'(bus.ALUSrcB), 8'd0);
        tick();
        chk("sub_s8", 8'(bus.state), 8'd8);
        chk("aluwb_regw", 8'(bus.RegWrite), 8'd1);
        tick();
        chk("sub_s0", 8'(bus.state), 8'd0);

        // I-type with the same fields: addi, not sub
        bus.op = 7'b0010011;
        tick();
        tick();
        chk("addi_s7", 8'(bus.state), 8'd7);
        chk("addi_alu", 8'(bus.ALUControl), 8'd0);
        chk("addi_srcb", 8'(bus.ALUSrcB), 8'd1);
        bus.funct3 = 3'b111;
        #1;
        chk("andi_alu", 8'(bus.ALUControl), 8'd2);
        tick();
        tick();
        chk("addi_s0", 8'(bus.state), 8'd0);

        // R-type slt and or
        bus.op = 7'b0110011;
        bus.funct3 = 3'b010;
        bus.funct7b5 = 1'b0;
        tick();
        tick();
        chk("slt_alu", 8'(bus.ALUControl), 8'd5);
        bus.funct3 = 3'b110;
        #1;
        chk("or_alu", 8'(bus.ALUControl), 8'd3);
        tick();
        tick();

        // beq taken
        bus.op = 7'b1100011;
        bus.zero_flag = 1'b1;
        #1;
        chk("beq_imm", 8'(bus.ImmSrc), 8'd2);
        tick();
        tick();
        chk("beq_s9", 8'(bus.state), 8'd9);
        chk("beq_t_pcw", 8'(bus.PCWrite), 8'd1);
        chk("beq_alu", 8'(bus.ALUControl), 8'd1);
        tick();
        chk("beq_s0", 8'(bus.state), 8'd0);

        // beq not taken
        bus.zero_flag = 1'b0;
        tick();
        tick();
        chk("beq_nt_pcw", 8'(bus.PCWrite), 8'd0);
        tick();

        // jal
        bus.op = 7'b1101111;
        #1;
        chk("jal_imm", 8'(bus.ImmSrc), 8'd3);
        tick();
        tick();
        chk("jal_s10", 8'(bus.state), 8'd10);
        chk("jal_pcw", 8'(bus.PCWrite), 8'd1);
        chk("jal_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("jal_srcb", 8'(bus.ALUSrcB), 8'd2);
        tick();
        chk("jal_s8", 8'(bus.state), 8'd8);
        tick();
        chk("jal_s0", 8'(bus.state), 8'd0);

        // asynchronous reset while stalled in MEMREAD
        bus.op = 7'b0000011;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("lwstall_s3", 8'(bus.state), 8'd3);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_state", 8'(bus.state), 8'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("async_pcw", 8'(bus.PCWrite), 8'd0);
        chk("async_irw", 8'(bus.IRWrite), 8'd0);
        tick();
        Reset = 1'b1;
        #1;
        chk("rel_pcw", 8'(bus.PCWrite), 8'd1);

        // unrecognised opcode
        bus.op = 7'b1111111;
        tick();
        chk("ill_s1", 8'(bus.state), 8'd1);
        tick();
`ifdef MC_CTRL_TRAP_EN
        chk("trap_state", 8'(bus.state), 8'd11);
        chk("trap_ill", 8'(bus.illegal_instr), 8'd1);
        tick();
        tick();
        chk("trap_hold", 8'(bus.state), 8'd11);
        chk("trap_pcw", 8'(bus.PCWrite), 8'd0);
        chk("trap_irw", 8'(bus.IRWrite), 8'd0);
        Reset = 1'b0;
        #1;
        chk("trap_exit", 8'(bus.state), 8'd0);
        chk("trap_ill_clr", 8'(bus.illegal_instr), 8'd0);
        tick();
        Reset = 1'b1;
`else
        chk("nop_s0", 8'(bus.state), 8'd0);
        chk("nop_pcw", 8'(bus.PCWrite), 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 Reset  in  1  asynchronous active-low reset; 0 = reset.
REQ-004 op  in  7  opcode from the instruction register (Instr[6:0]).
REQ-005 funct3  in  3  Instr[14:12].
REQ-006 funct7b5  in  1  Instr[30].
REQ-007 zero_flag  in  1  ALU zero output.
REQ-008 mem_ready  in  1  shared memory completes the current access this cycle.
REQ-009 PCWrite  out  1  PC register load enable.
REQ-010 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 MemWrite  out  1  memory write strobe.
REQ-012 IRWrite  out  1  instruction register and OldPC load enable.
REQ-013 ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
REQ-015 ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-016 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 RegWrite  out  1  register file write enable.
REQ-019 state  out  4  current FSM state, for debug.

Function
REQ-020 Moore FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-021 Transitions:
- FETCH->DECODE when mem_ready=1, else stay in FETCH.
- DECODE->MEMADR on op 0000011 or 0100011; EXECR on 0110011; EXECI on 0010011; BEQ on 1100011; JAL on 1101111.
- MEMADR->MEMREAD for lw, MEMWRITE for sw.
- MEMREAD->MEMWB when mem_ready=1, else stay.
- MEMWRITE->FETCH when mem_ready=1, else stay.
- EXECR and EXECI->ALUWB.
- JAL->ALUWB.
- MEMWB, ALUWB and BEQ->FETCH.
REQ-022 Unlisted states SHALL go to FETCH.
REQ-023 Per-state outputs (any output not listed is 0):
- FETCH: ALUSrcB=10, ResultSrc=10, IRWrite=mem_ready, PCUpdate=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-024 PCWrite = PCUpdate | (Branch & zero_flag).
REQ-025 PCWrite and IRWrite SHALL each pulse for exactly one cycle per fetch, whatever the number of stall cycles.
REQ-026 ImmSrc is combinational from op in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other opcodes -> 00.
REQ-027 ALU decode:
- ALUOp 00 -> 000.
- ALUOp 01 -> 001.
- ALUOp 10, funct3 000 -> 001 if {op[5],funct7b5}=11, else 000.
- ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-028 MemWrite SHALL remain high for every stalled cycle in MEMWRITE and fall in the cycle after the state leaves MEMWRITE.
REQ-029 Instruction latency with mem_ready held at 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-030 While Reset=0: state=FETCH, and PCWrite, IRWrite, MemWrite and RegWrite are all 0, regardless of mem_ready.
REQ-031 Asserting Reset in any state, including mid-stall, SHALL return the FSM to FETCH immediately and asynchronously.
REQ-032 After Reset deasserts, the first active PCWrite/IRWrite occurs no earlier than the first rising edge with mem_ready=1.

Configuration
REQ-033 Macro MC_CTRL_TRAP_EN.
- Defined: an unrecognised op in DECODE goes to TRAP. TRAP holds indefinitely with all strobes 0, and output illegal_instr (1 bit) = 1 in TRAP and 0 otherwise. Only Reset exits TRAP.
- Undefined: an unrecognised op in DECODE goes to FETCH, behaving as a 2-cycle NOP. No TRAP state and no illegal_instr port exist.

Verification
REQ-034 Reset low for 3 cycles with mem_ready=1 -> state=0; PCWrite=IRWrite=MemWrite=RegWrite=0 throughout.
REQ-035 lw (op 0000011) with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in state 4.
REQ-036 sw with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; next state is FETCH.
REQ-037 beq: zero_flag=1 -> PCWrite=1 in BEQ with ALUControl=001; zero_flag=0 -> PCWrite=0.
REQ-038 R-type, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. Same fields on op 0010011 -> 000.
REQ-039 op 1111111 -> with MC_CTRL_TRAP_EN, state=11 and illegal_instr=1 until Reset; without it, state returns to 0 after DECODE.
